// File: rtl/cmp_steer_pkg.sv
// Shared types and helpers for the cmp_mem_steer memory-request steering unit.
package cmp_steer_pkg;

    // Return source recorded for an in-flight read
    localparam logic TGT_DMEM = 1'b0;
    localparam logic TGT_NIC  = 1'b1;

    // One return slot: a read is due back in this slot, from source src
    typedef struct packed {
        logic valid;
        logic src;
    } slot_t;

    // Depth of the return-slot shift register
    function automatic int MAX_LAT(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cmp_steer_lane.sv
// One node of cmp_mem_steer: request decode, return-slot tracking, stall
// generation and read-data return mux.
// Optional perf counters are built when CMP_MEM_STEER_PERF_CNT_EN is defined.
module cmp_steer_lane
    import cmp_steer_pkg::*;
#(
    parameter int         DATA_W      = 64,
    parameter logic [1:0] NIC_SEL_VAL = 2'b11,
    parameter int         DMEM_RD_LAT = 1,
    parameter int         NIC_RD_LAT  = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        i_sel_field,
    input  logic              i_memEn,
    input  logic              i_memWrEn,
    input  logic [DATA_W-1:0] i_dmem_din,
    input  logic [DATA_W-1:0] i_nic_do,
    output logic              o_dmem_memEn,
    output logic              o_dmem_memWrEn,
    output logic              o_nic_en,
    output logic              o_nic_wr_en,
    output logic [DATA_W-1:0] o_din,
    output logic              o_rd_valid,
`ifdef CMP_MEM_STEER_PERF_CNT_EN
    output logic [15:0]       o_perf_nic_cnt,
    output logic [15:0]       o_perf_stall_cnt,
`endif
    output logic              o_stall
);

    localparam int D = MAX_LAT(DMEM_RD_LAT, NIC_RD_LAT);

    // r_slot[j] describes the read returning j cycles from now
    slot_t [D-1:0] r_slot;
    slot_t [D-1:0] w_slot_nxt;

    logic w_hit_nic;
    logic w_is_rd;
    logic w_owned;
    logic w_accept;
    int   w_lat;

    // Decode, collision check and target strobes
    always_comb begin
        w_hit_nic = i_memEn && (i_sel_field == NIC_SEL_VAL);
        // memEn with memWrEn is a write, so only pure reads occupy slots
        w_is_rd   = i_memEn && !i_memWrEn;
        w_lat     = w_hit_nic ? NIC_RD_LAT : DMEM_RD_LAT;
        // The return cycle issue+L is already owned if slot L is valid now;
        // L == D lies beyond the register and is always free
        w_owned   = 1'b0;
        for (int j = 0; j < D; j++) begin
            if (j == w_lat) w_owned = r_slot[j].valid;
        end
        o_stall        = w_is_rd && w_owned && !RESET;
        w_accept       = i_memEn && !o_stall && !RESET;
        o_nic_en       = w_accept && w_hit_nic;
        o_nic_wr_en    = w_accept && w_hit_nic && i_memWrEn;
        o_dmem_memEn   = w_accept && !w_hit_nic;
        o_dmem_memWrEn = w_accept && !w_hit_nic && i_memWrEn;
    end

    // Return mux: recorded source in a return cycle, dmem data otherwise
    always_comb begin
        o_rd_valid = r_slot[0].valid && !RESET;
        o_din      = i_dmem_din;
        if (o_rd_valid && (r_slot[0].src == TGT_NIC)) o_din = i_nic_do;
    end

    // Next slot state: shift toward slot 0, then record an accepted read
    always_comb begin
        w_slot_nxt = '0;
        for (int j = 0; j < D - 1; j++) begin
            w_slot_nxt[j] = r_slot[j+1];
        end
        for (int j = 0; j < D; j++) begin
            if (w_accept && w_is_rd && (j == w_lat - 1)) begin
                w_slot_nxt[j].valid = 1'b1;
                w_slot_nxt[j].src   = w_hit_nic ? TGT_NIC : TGT_DMEM;
            end
        end
    end

    // Slot register; reset discards every in-flight read
    always_ff @(posedge CLK) begin
        if (RESET) r_slot <= '0;
        else       r_slot <= w_slot_nxt;
    end

`ifdef CMP_MEM_STEER_PERF_CNT_EN
    logic [15:0] r_perf_nic_cnt;
    logic [15:0] r_perf_stall_cnt;

    // Saturating counters of accepted NIC accesses and stall cycles
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_perf_nic_cnt   <= '0;
            r_perf_stall_cnt <= '0;
        end else begin
            if (o_nic_en && (r_perf_nic_cnt != 16'hFFFF))
                r_perf_nic_cnt <= r_perf_nic_cnt + 16'd1;
            if (o_stall && (r_perf_stall_cnt != 16'hFFFF))
                r_perf_stall_cnt <= r_perf_stall_cnt + 16'd1;
        end
    end

    assign o_perf_nic_cnt   = r_perf_nic_cnt;
    assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: rtl/cmp_mem_steer.sv
// Per-node memory-request steering between NODES processors, their data
// memories and the NIC. Buses are big-endian: node i owns [i*W : i*W+W-1].
// Define CMP_MEM_STEER_PERF_CNT_EN to add the perf_nic_cnt/perf_stall_cnt outputs.
module cmp_mem_steer
    import cmp_steer_pkg::*;
#(
    parameter int         NODES       = 4,
    parameter int         DATA_W      = 64,
    parameter int         ADDR_W      = 32,
    parameter int         NIC_SEL_MSB = 16,
    parameter logic [1:0] NIC_SEL_VAL = 2'b11,
    parameter int         NIC_ADDR_W  = 2,
    parameter int         DMEM_RD_LAT = 1,
    parameter int         NIC_RD_LAT  = 1
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [0:NODES*ADDR_W-1]      proc_addr,
    input  logic [0:NODES*DATA_W-1]      proc_dout,
    input  logic [0:NODES-1]             proc_memEn,
    input  logic [0:NODES-1]             proc_memWrEn,
    output logic [0:NODES*DATA_W-1]      proc_din,
    output logic [0:NODES-1]             proc_rd_valid,
    output logic [0:NODES-1]             proc_stall,
    output logic [0:NODES*ADDR_W-1]      dmem_addr,
    output logic [0:NODES*DATA_W-1]      dmem_dout,
    output logic [0:NODES-1]             dmem_memEn,
    output logic [0:NODES-1]             dmem_memWrEn,
    input  logic [0:NODES*DATA_W-1]      dmem_din,
    output logic [0:NODES*NIC_ADDR_W-1]  nic_addr,
    output logic [0:NODES*DATA_W-1]      nic_di,
    output logic [0:NODES-1]             nic_en,
    output logic [0:NODES-1]             nic_wr_en,
`ifdef CMP_MEM_STEER_PERF_CNT_EN
    output logic [0:NODES*16-1]          perf_nic_cnt,
    output logic [0:NODES*16-1]          perf_stall_cnt,
`endif
    input  logic [0:NODES*DATA_W-1]      nic_do
);

    // Address and write data pass straight through to both targets
    assign dmem_addr = proc_addr;
    assign dmem_dout = proc_dout;
    assign nic_di    = proc_dout;

    for (genvar i = 0; i < NODES; i++) begin : g_lane
        logic [1:0] w_sel_field;

        assign w_sel_field = proc_addr[i*ADDR_W + NIC_SEL_MSB +: 2];
        assign nic_addr[i*NIC_ADDR_W +: NIC_ADDR_W] =
            proc_addr[i*ADDR_W + ADDR_W - NIC_ADDR_W +: NIC_ADDR_W];

        cmp_steer_lane #(
            .DATA_W      (DATA_W),
            .NIC_SEL_VAL (NIC_SEL_VAL),
            .DMEM_RD_LAT (DMEM_RD_LAT),
            .NIC_RD_LAT  (NIC_RD_LAT)
        ) u_lane (
            .CLK            (CLK),
            .RESET          (RESET),
            .i_sel_field    (w_sel_field),
            .i_memEn        (proc_memEn[i]),
            .i_memWrEn      (proc_memWrEn[i]),
            .i_dmem_din     (dmem_din[i*DATA_W +: DATA_W]),
            .i_nic_do       (nic_do[i*DATA_W +: DATA_W]),
            .o_dmem_memEn   (dmem_memEn[i]),
            .o_dmem_memWrEn (dmem_memWrEn[i]),
            .o_nic_en       (nic_en[i]),
            .o_nic_wr_en    (nic_wr_en[i]),
            .o_din          (proc_din[i*DATA_W +: DATA_W]),
            .o_rd_valid     (proc_rd_valid[i]),
`ifdef CMP_MEM_STEER_PERF_CNT_EN
            .o_perf_nic_cnt   (perf_nic_cnt[i*16 +: 16]),
            .o_perf_stall_cnt (perf_stall_cnt[i*16 +: 16]),
`endif
            .o_stall        (proc_stall[i])
        );
    end

endmodule

// File: tb/tb_cmp_mem_steer.sv
// Bench for cmp_mem_steer: DUT a uses equal latencies (1/1), DUT b uses
// DMEM_RD_LAT=2, NIC_RD_LAT=1. Both share the request inputs.
module tb_cmp_mem_steer;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 32;

    localparam logic [63:0] DBASE = 64'hD000_0000_0000_0000;
    localparam logic [63:0] ABASE = 64'hA000_0000_0000_0000;

    logic CLK = 1'b0;
    logic RESET;
    logic [0:N*AW-1] proc_addr;
    logic [0:N*DW-1] proc_dout;
    logic [0:N-1]    proc_memEn, proc_memWrEn;
    logic [0:N*DW-1] dmem_din, nic_do;

    logic [0:N*DW-1] a_din, b_din;
    logic [0:N-1]    a_rdv, b_rdv, a_stall, b_stall;
    logic [0:N*AW-1] a_daddr, b_daddr;
    logic [0:N*DW-1] a_ddout, b_ddout, a_ndi, b_ndi;
    logic [0:N-1]    a_den, a_dwr, a_nen, a_nwr, b_den, b_dwr, b_nen, b_nwr;
    logic [0:N*2-1]  a_naddr, b_naddr;
`ifdef CMP_MEM_STEER_PERF_CNT_EN
    logic [0:N*16-1] a_pnic, a_pstl, b_pnic, b_pstl;
`endif

    always #5 CLK = ~CLK;

    cmp_mem_steer #(.DMEM_RD_LAT(1), .NIC_RD_LAT(1)) u_dut_a (
        .CLK(CLK), .RESET(RESET),
        .proc_addr(proc_addr), .proc_dout(proc_dout),
        .proc_memEn(proc_memEn), .proc_memWrEn(proc_memWrEn),
        .proc_din(a_din), .proc_rd_valid(a_rdv), .proc_stall(a_stall),
        .dmem_addr(a_daddr), .dmem_dout(a_ddout),
        .dmem_memEn(a_den), .dmem_memWrEn(a_dwr), .dmem_din(dmem_din),
        .nic_addr(a_naddr), .nic_di(a_ndi), .nic_en(a_nen), .nic_wr_en(a_nwr),
`ifdef CMP_MEM_STEER_PERF_CNT_EN
        .perf_nic_cnt(a_pnic), .perf_stall_cnt(a_pstl),
`endif
        .nic_do(nic_do)
    );

    cmp_mem_steer #(.DMEM_RD_LAT(2), .NIC_RD_LAT(1)) u_dut_b (
        .CLK(CLK), .RESET(RESET),
        .proc_addr(proc_addr), .proc_dout(proc_dout),
        .proc_memEn(proc_memEn), .proc_memWrEn(proc_memWrEn),
        .proc_din(b_din), .proc_rd_valid(b_rdv), .proc_stall(b_stall),
        .dmem_addr(b_daddr), .dmem_dout(b_ddout),
        .dmem_memEn(b_den), .dmem_memWrEn(b_dwr), .dmem_din(dmem_din),
        .nic_addr(b_naddr), .nic_di(b_ndi), .nic_en(b_nen), .nic_wr_en(b_nwr),
`ifdef CMP_MEM_STEER_PERF_CNT_EN
        .perf_nic_cnt(b_pnic), .perf_stall_cnt(b_pstl),
`endif
        .nic_do(nic_do)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {dmem_memEn, dmem_memWrEn, nic_en, nic_wr_en} of one node
    function automatic logic [3:0] a_strb(input int n);
        return {a_den[n], a_dwr[n], a_nen[n], a_nwr[n]};
    endfunction
    function automatic logic [3:0] b_strb(input int n);
        return {b_den[n], b_dwr[n], b_nen[n], b_nwr[n]};
    endfunction

    // Drive one node's request; every other node idles
    task automatic drive(input int n, input logic [31:0] addr, input logic en, input logic wr);
        proc_addr    = '0;
        proc_dout    = '0;
        proc_memEn   = '0;
        proc_memWrEn = '0;
        proc_addr[n*AW +: AW] = addr;
        proc_dout[n*DW +: DW] = {addr, ~addr};
        proc_memEn[n]   = en;
        proc_memWrEn[n] = wr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        en;
        logic        wr;
        logic [3:0]  strb;
        logic        stall;
        logic        rdv;
        logic [63:0] din;
        logic [1:0]  naddr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [63:0] D1, A1, D2, A2;
        D1 = DBASE | 64'd1; A1 = ABASE | 64'd1;
        D2 = DBASE | 64'd2; A2 = ABASE | 64'd2;

        // Node 1 on DUT a, latency 1 everywhere: rdv reflects previous vector
        tbl[0]  = '{32'h0000_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, D1, 2'b00};
        tbl[1]  = '{32'h0000_C003, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, D1, 2'b11};
        tbl[2]  = '{32'h0000_0010, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, A1, 2'b00};
        tbl[3]  = '{32'h0000_0020, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b1, D1, 2'b00};
        tbl[4]  = '{32'h0000_C001, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, D1, 2'b01};
        tbl[5]  = '{32'h0000_C002, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, D1, 2'b10};
        tbl[6]  = '{32'h0000_C000, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, A1, 2'b00};
        tbl[7]  = '{32'h0000_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, A1, 2'b00};
        tbl[8]  = '{32'h0000_8000, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b0, D1, 2'b00};
        tbl[9]  = '{32'h0000_4000, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, D1, 2'b00};
        tbl[10] = '{32'h0000_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, D1, 2'b00};
        tbl[11] = '{32'h0000_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, D1, 2'b00};

        for (int n = 0; n < N; n++) begin
            dmem_din[n*DW +: DW] = DBASE | 64'(n);
            nic_do[n*DW +: DW]   = ABASE | 64'(n);
        end

        RESET = 1'b1;
        drive(0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        // Strobes forced low during reset even with a live request
        drive(1, 32'h0000_C003, 1'b1, 1'b0);
        #3;
        chk("rst_strb_a", 64'(a_strb(1)), 64'h0);
        chk("rst_strb_b", 64'(b_strb(1)), 64'h0);
        chk("rst_rdv", 64'({a_rdv, b_rdv}), 64'h0);
        chk("rst_stall", 64'({a_stall, b_stall}), 64'h0);
        tick();
        RESET = 1'b0;
        drive(0, 32'h0, 1'b0, 1'b0);

        for (int v = 0; v < 12; v++) begin
            tick();
            drive(1, tbl[v].addr, tbl[v].en, tbl[v].wr);
            #3;
            chk($sformatf("v%0d_strb", v), 64'(a_strb(1)), 64'(tbl[v].strb));
            chk($sformatf("v%0d_stall", v), 64'(a_stall[1]), 64'(tbl[v].stall));
            chk($sformatf("v%0d_rdv", v), 64'(a_rdv[1]), 64'(tbl[v].rdv));
            chk($sformatf("v%0d_din", v), a_din[1*DW +: DW], tbl[v].din);
            chk($sformatf("v%0d_naddr", v), 64'(a_naddr[2 +: 2]), 64'(tbl[v].naddr));
            chk($sformatf("v%0d_daddr", v), 64'(a_daddr[1*AW +: AW]), 64'(tbl[v].addr));
            chk($sformatf("v%0d_ndi", v), a_ndi[1*DW +: DW], {tbl[v].addr, ~tbl[v].addr});
            chk($sformatf("v%0d_node0", v), 64'({a_strb(0), a_rdv[0], a_stall[0]}), 64'h0);
        end

        // Collision on DUT b node 2: dmem read (L=2) then NIC read (L=1)
        tick(); drive(2, 32'h0000_0010, 1'b1, 1'b0); #3;
        chk("col_t0_strb", 64'(b_strb(2)), 64'b1000);
        chk("col_t0_stall", 64'(b_stall[2]), 64'h0);
        tick(); drive(2, 32'h0000_C003, 1'b1, 1'b0); #3;
        chk("col_t1_stall", 64'(b_stall[2]), 64'h1);
        chk("col_t1_strb", 64'(b_strb(2)), 64'h0);
        chk("col_t1_rdv", 64'(b_rdv[2]), 64'h0);
        chk("eq_lat_nostall", 64'(a_stall[2]), 64'h0);
        tick(); drive(2, 32'h0000_C003, 1'b1, 1'b0); #3;
        chk("col_t2_stall", 64'(b_stall[2]), 64'h0);
        chk("col_t2_strb", 64'(b_strb(2)), 64'b0010);
        chk("col_t2_rdv", 64'(b_rdv[2]), 64'h1);
        chk("col_t2_din", b_din[2*DW +: DW], D2);
        tick(); drive(2, 32'h0, 1'b0, 1'b0); #3;
        chk("col_t3_rdv", 64'(b_rdv[2]), 64'h1);
        chk("col_t3_din", b_din[2*DW +: DW], A2);
        tick(); #3;
        chk("col_t4_rdv", 64'(b_rdv[2]), 64'h0);
`ifdef CMP_MEM_STEER_PERF_CNT_EN
        chk("perf_stall_b2", 64'(b_pstl[2*16 +: 16]), 64'd1);
        chk("perf_stall_a2", 64'(a_pstl[2*16 +: 16]), 64'd0);
`endif

        // DUT b: back-to-back dmem reads, then NIC write behind a dmem read
        tick(); drive(2, 32'h0000_0010, 1'b1, 1'b0); #3;
        tick(); drive(2, 32'h0000_0018, 1'b1, 1'b0); #3;
        chk("b2b_stall", 64'(b_stall[2]), 64'h0);
        chk("b2b_strb", 64'(b_strb(2)), 64'b1000);
        tick(); drive(2, 32'h0000_0010, 1'b1, 1'b0); #3;
        chk("b2b_rdv0", 64'(b_rdv[2]), 64'h1);
        tick(); drive(2, 32'h0000_C000, 1'b1, 1'b1); #3;
        chk("nicwr_stall", 64'(b_stall[2]), 64'h0);
        chk("nicwr_strb", 64'(b_strb(2)), 64'b0011);
        chk("nicwr_ndi", b_ndi[2*DW +: DW], {32'h0000_C000, ~32'h0000_C000});
        chk("b2b_rdv1", 64'(b_rdv[2]), 64'h1);
        tick(); drive(2, 32'h0, 1'b0, 1'b0); #3;
        chk("b2b_rdv2", 64'(b_rdv[2]), 64'h1);
        chk("b2b_din2", b_din[2*DW +: DW], D2);
        tick(); #3;
        chk("nicwr_no_rdv", 64'(b_rdv[2]), 64'h0);

`ifdef CMP_MEM_STEER_PERF_CNT_EN
        // Saturation: 70000 NIC writes on node 2
        tick(); drive(2, 32'h0000_C000, 1'b1, 1'b1);
        repeat (70000) tick();
        drive(2, 32'h0, 1'b0, 1'b0);
        tick(); #3;
        chk("perf_sat_a2", 64'(a_pnic[2*16 +: 16]), 64'hFFFF);
        chk("perf_nic_a0", 64'(a_pnic[0 +: 16]), 64'd0);
`endif

        // Reset mid-flight: node 0 dmem read, then RESET the next cycle
        tick(); drive(0, 32'h0000_0010, 1'b1, 1'b0); #3;
        chk("mf_issue_a", 64'(a_strb(0)), 64'b1000);
        chk("mf_issue_b", 64'(b_strb(0)), 64'b1000);
        tick(); RESET = 1'b1; drive(0, 32'h0000_C003, 1'b1, 1'b0); #3;
        chk("mf_rst_rdv", 64'({a_rdv, b_rdv}), 64'h0);
        chk("mf_rst_strb", 64'({a_strb(0), b_strb(0)}), 64'h0);
        chk("mf_rst_stall", 64'({a_stall, b_stall}), 64'h0);
        tick(); RESET = 1'b0; drive(0, 32'h0, 1'b0, 1'b0); #3;
        chk("mf_after_rdv_b", 64'(b_rdv[0]), 64'h0);
        chk("mf_after_rdv_a", 64'(a_rdv[0]), 64'h0);
        chk("mf_after_din", b_din[0 +: DW], DBASE);
`ifdef CMP_MEM_STEER_PERF_CNT_EN
        chk("perf_rst_a2", 64'(a_pnic[2*16 +: 16]), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
